// File: rtl/egress_link.sv
// egress_link: output buffer plus transmit serializer for dequeued packets.
// Accepted packets are queued in a small FIFO, then sent as a run of line
// beats (sop..eop) followed by an inter-frame gap of idle cycles.
// Optional statistics counters are built only when EGRESS_LINK_STATS_EN is defined.
module egress_link #(
    parameter int DATA_W          = 32,
    parameter int LEN_W           = 11,
    parameter int BYTES_PER_CYCLE = 8,
    parameter int OBUF_DEPTH      = 4,
    parameter int IFG_CYCLES      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i__packet_valid,
    input  logic [DATA_W-1:0] i__packet_data,
    input  logic [LEN_W-1:0]  i__packet_len,
    input  logic              i__drop,
    output logic              o__link_ready,
    output logic              o__tx_valid,
    output logic [DATA_W-1:0] o__tx_data,
    output logic              o__tx_sop,
    output logic              o__tx_eop,
    output logic [31:0]       o__tx_count,
    output logic [31:0]       o__drop_count,
    output logic [31:0]       o__overflow_count
);
    localparam int PTR_W  = $clog2(OBUF_DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int SHIFT  = $clog2(BYTES_PER_CYCLE);
    localparam int BEAT_W = LEN_W + 1;
    localparam int GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t            state;
    state_t            state_next;

    logic [DATA_W-1:0] buf_data [OBUF_DEPTH];
    logic [LEN_W-1:0]  buf_len  [OBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;

    logic              accept;
    logic              push;
    logic              pop;
    logic [BEAT_W-1:0] len_round;
    logic [BEAT_W-1:0] head_beats;
    logic [BEAT_W-1:0] beat_total;
    logic [BEAT_W-1:0] beat_idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] cur_data;
    logic              last_beat;
    logic              gap_done;

    // Ready comes only from registered occupancy and is held low during reset.
    always_comb begin
        o__link_ready = !reset && (occ < OCC_W'(OBUF_DEPTH));
        accept        = i__packet_valid && o__link_ready;
        push          = accept && !i__drop;
    end

    // Beat count of the head entry: ceil(len / BYTES_PER_CYCLE), minimum one.
    always_comb begin
        len_round  = BEAT_W'(buf_len[rd_ptr]) + BEAT_W'(BYTES_PER_CYCLE - 1);
        head_beats = len_round >> SHIFT;
        if (head_beats == '0) begin
            head_beats = BEAT_W'(1);
        end
        last_beat = (beat_idx + BEAT_W'(1)) == beat_total;
        gap_done  = (32'(gap_cnt) + 32'd1) >= 32'(IFG_CYCLES);
    end

    // FIFO storage; written only on a non-dropped accept.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= i__packet_data;
            buf_len[wr_ptr]  <= i__packet_len;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at OBUF_DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Transmit FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and line outputs.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        o__tx_valid = 1'b0;
        o__tx_sop   = 1'b0;
        o__tx_eop   = 1'b0;
        case (state)
            // Leaving IDLE also considers this cycle's push, so a packet
            // accepted into an empty buffer is loaded on the very next cycle.
            IDLE: if (occ != '0 || push) state_next = LOAD;
            LOAD: begin
                pop        = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                o__tx_valid = 1'b1;
                o__tx_sop   = (beat_idx == '0);
                o__tx_eop   = last_beat;
                if (last_beat) state_next = (IFG_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: if (gap_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        o__tx_data = o__tx_valid ? cur_data : '0;
    end

    // Per-packet beat/gap counters and the descriptor held on the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_total <= '0;
            beat_idx   <= '0;
            gap_cnt    <= '0;
            cur_data   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    beat_total <= head_beats;
                    beat_idx   <= '0;
                    gap_cnt    <= '0;
                    cur_data   <= buf_data[rd_ptr];
                end
                SEND:    beat_idx <= beat_idx + BEAT_W'(1);
                GAP:     gap_cnt  <= gap_cnt + GAP_W'(1);
                default: ;
            endcase
        end
    end

`ifdef EGRESS_LINK_STATS_EN
    logic [31:0] tx_count;
    logic [31:0] drop_count;
    logic [31:0] overflow_count;

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_count       <= '0;
            drop_count     <= '0;
            overflow_count <= '0;
        end else begin
            if (o__tx_eop && tx_count != '1)
                tx_count <= tx_count + 32'd1;
            if (accept && i__drop && drop_count != '1)
                drop_count <= drop_count + 32'd1;
            if (i__packet_valid && !o__link_ready && overflow_count != '1)
                overflow_count <= overflow_count + 32'd1;
        end
    end

    assign o__tx_count       = tx_count;
    assign o__drop_count     = drop_count;
    assign o__overflow_count = overflow_count;
`else
    assign o__tx_count       = '0;
    assign o__drop_count     = '0;
    assign o__overflow_count = '0;
`endif

endmodule

// File: tb/tb_egress_link.sv
// tb_egress_link: directed vector table plus hand-written multi-cycle
// sequences (buffer fill/overflow, reset mid-packet) for egress_link.
// Counter expectations follow the EGRESS_LINK_STATS_EN build setting.
module tb_egress_link;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        packet_valid = 1'b0;
    logic [31:0] packet_data = '0;
    logic [10:0] packet_len = '0;
    logic        drop = 1'b0;
    logic        link_ready;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_sop;
    logic        tx_eop;
    logic [31:0] tx_count;
    logic [31:0] drop_count;
    logic [31:0] overflow_count;

    int errors = 0;
    int checks = 0;

`ifdef EGRESS_LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    egress_link #(
        .DATA_W(32),
        .LEN_W(11),
        .BYTES_PER_CYCLE(8),
        .OBUF_DEPTH(4),
        .IFG_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i__packet_valid(packet_valid),
        .i__packet_data(packet_data),
        .i__packet_len(packet_len),
        .i__drop(drop),
        .o__link_ready(link_ready),
        .o__tx_valid(tx_valid),
        .o__tx_data(tx_data),
        .o__tx_sop(tx_sop),
        .o__tx_eop(tx_eop),
        .o__tx_count(tx_count),
        .o__drop_count(drop_count),
        .o__overflow_count(overflow_count)
    );

    typedef struct {
        logic        v;
        logic        d;
        logic [10:0] len;
        logic [31:0] data;
        logic        rdy;
        logic        tv;
        logic        sop;
        logic        eop;
        logic [31:0] td;
    } vec_t;

    vec_t vecs[$];

    // Negedge line monitor used by the buffer-fill sequence.
    logic        mon_en = 1'b0;
    logic [34:0] mon_log[$];

    always @(negedge clk) begin
        if (mon_en) mon_log.push_back({tx_valid, tx_sop, tx_eop, tx_data});
    end

    function automatic logic [31:0] stat(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic d, input logic [10:0] len, input logic [31:0] data);
        packet_valid = v;
        drop         = d;
        packet_len   = len;
        packet_data  = data;
    endtask

    task automatic add(input logic v, input logic d, input logic [10:0] len, input logic [31:0] data,
                       input logic rdy, input logic tv, input logic sop, input logic eop, input logic [31:0] td);
        vec_t e;
        e.v = v; e.d = d; e.len = len; e.data = data;
        e.rdy = rdy; e.tv = tv; e.sop = sop; e.eop = eop; e.td = td;
        vecs.push_back(e);
    endtask

    task automatic add_idle(input int n);
        for (int k = 0; k < n; k++) add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic check_counters(input string tag, input int tx, input int dr, input int ov);
        check({tag, ".tx_count"}, 64'(tx_count), 64'(stat(tx)));
        check({tag, ".drop_count"}, 64'(drop_count), 64'(stat(dr)));
        check({tag, ".overflow_count"}, 64'(overflow_count), 64'(stat(ov)));
    endtask

    initial begin
        logic [31:0] q_data[5];
        logic [31:0] pkt_data;
        logic [34:0] exp_beat;
        int          idle_beats;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("reset.link_ready", 64'(link_ready), 64'd0);
        check("reset.tx_valid", 64'(tx_valid), 64'd0);
        check("reset.tx_data", 64'(tx_data), 64'd0);
        check_counters("reset", 0, 0, 0);
        reset = 1'b0;   // current cycle is cycle 0

        // ---------------- vector table ----------------
        // len=20 accepted in cycle 5: LOAD 6, beats 7..9, GAP 10..11
        add_idle(5);
        add(1, 0, 20, 32'hA000_0014, 1, 0, 0, 0, 0);
        add_idle(1);
        add(0, 0, 0, 0, 1, 1, 1, 0, 32'hA000_0014);
        add(0, 0, 0, 0, 1, 1, 0, 0, 32'hA000_0014);
        add(0, 0, 0, 0, 1, 1, 0, 1, 32'hA000_0014);
        add_idle(3);
        // len=0 then len=8 back to back: single beats, GAP(2)+IDLE+LOAD between
        add(1, 0, 0, 32'hB000_0000, 1, 0, 0, 0, 0);
        add(1, 0, 8, 32'hC000_0008, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 1, 32'hB000_0000);
        add_idle(4);
        add(0, 0, 0, 0, 1, 1, 1, 1, 32'hC000_0008);
        add_idle(3);
        // dropped packet never reaches the line
        add(1, 1, 100, 32'hD000_0064, 1, 0, 0, 0, 0);
        add_idle(7);
        // len=9 rounds up to two beats
        add(1, 0, 9, 32'hE000_0009, 1, 0, 0, 0, 0);
        add_idle(1);
        add(0, 0, 0, 0, 1, 1, 1, 0, 32'hE000_0009);
        add(0, 0, 0, 0, 1, 1, 0, 1, 32'hE000_0009);
        add_idle(3);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].len, vecs[i].data);
            #2;
            check($sformatf("vec%0d", i),
                  64'({link_ready, tx_valid, tx_sop, tx_eop, tx_data}),
                  64'({vecs[i].rdy, vecs[i].tv, vecs[i].sop, vecs[i].eop, vecs[i].td}));
            cycle();
        end
        drive(0, 0, 0, 0);
        check_counters("table", 4, 1, 0);

        // ---------------- buffer fill / overflow ----------------
        // An 8-beat packet keeps the transmitter busy, so the next five
        // consecutive packets land in the buffer: four fill it, the fifth
        // arrives with link_ready low and is ignored.
        for (int k = 0; k < 5; k++) q_data[k] = 32'hF000_0001 + 32'(k);
        drive(1, 0, 64, 32'hF000_0000);
        #2;
        check("fill.prime_ready", 64'(link_ready), 64'd1);
        cycle();
        drive(0, 0, 0, 0);
        cycle();                      // LOAD of priming packet
        mon_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 64, q_data[k]);
            #2;
            check($sformatf("fill.ready%0d", k), 64'(link_ready), (k < 4) ? 64'd1 : 64'd0);
            cycle();
        end
        drive(0, 0, 0, 0);
        #2;
        check("fill.ready_after", 64'(link_ready), 64'd0);
        repeat (65) cycle();
        mon_en = 1'b0;
        check("fill.log_size", 64'(mon_log.size()), 64'd70);
        for (int o = 0; o < mon_log.size() && o < 70; o++) begin
            exp_beat = '0;
            if (o / 12 < 5 && o % 12 < 8) begin
                pkt_data = (o / 12 == 0) ? 32'hF000_0000 : q_data[o / 12 - 1];
                exp_beat = {1'b1, (o % 12 == 0), (o % 12 == 7), pkt_data};
            end
            check($sformatf("fill.beat%0d", o), 64'(mon_log[o]), 64'(exp_beat));
        end
        check("fill.ready_end", 64'(link_ready), 64'd1);
        check_counters("fill", 9, 1, 1);

        // ---------------- reset mid-packet ----------------
        drive(1, 0, 40, 32'h5000_0028);
        cycle();
        drive(0, 0, 0, 0);
        cycle();                      // LOAD
        #2;
        check("rst.beat1", 64'({tx_valid, tx_sop, tx_eop}), 64'b110);
        cycle();
        #2;
        check("rst.beat2", 64'({tx_valid, tx_sop, tx_eop, tx_data}), 64'({3'b100, 32'h5000_0028}));
        reset = 1'b1;
        #1;
        check("rst.ready_in_reset", 64'(link_ready), 64'd0);
        cycle();
        reset = 1'b0;
        #2;
        check("rst.after", 64'({tx_valid, tx_eop, tx_data}), 64'd0);
        check("rst.ready_after", 64'(link_ready), 64'd1);
        check_counters("rst", 0, 0, 0);
        idle_beats = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            #2;
            if (tx_valid || tx_eop) idle_beats++;
        end
        check("rst.no_beats", 64'(idle_beats), 64'd0);

        // transmitter restarts cleanly after reset
        drive(1, 0, 16, 32'h6000_0010);
        cycle();
        drive(0, 0, 0, 0);
        cycle();
        #2;
        check("post.sop", 64'({tx_valid, tx_sop, tx_eop, tx_data}), 64'({3'b110, 32'h6000_0010}));
        cycle();
        #2;
        check("post.eop", 64'({tx_valid, tx_sop, tx_eop, tx_data}), 64'({3'b101, 32'h6000_0010}));
        cycle();
        #2;
        check("post.gap", 64'(tx_valid), 64'd0);
        check_counters("post", 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
